// File: rtl/pulse_dec_timer_pkg.sv
// Shared types and constants for the BCD MM:SS countdown timer.
// Latency: n/a (package only).
// Backpressure: n/a.
//
// Contents: FSM state encoding, BCD digit width, default digit maxima,
// and a digit clamp helper used when a set value is loaded.
package pulse_dec_timer_pkg;

  localparam int BCD_W = 4;

  localparam logic [BCD_W-1:0] SEC_TENS_MAX_DEF = 4'd5;
  localparam logic [BCD_W-1:0] DIGIT_MAX_DEF    = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Saturate a loaded digit to the largest value that digit may show.
  function automatic logic [BCD_W-1:0] clamp_digit(
    input logic [BCD_W-1:0] d,
    input logic [BCD_W-1:0] max
  );
    return (d > max) ? max : d;
  endfunction

endpackage

// File: rtl/pulse_dec_timer_bcd_dec_digit.sv
// One BCD digit of the countdown chain: decrement with wrap-to-MAX and borrow.
// Latency: combinational, zero cycles.
// Backpressure: none; result is valid whenever inputs are.
//
// Ports:
//   i_digit   current digit value
//   i_dec_en  decrement this digit (borrow from the less significant digit)
//   o_digit   next digit value
//   o_borrow  digit wrapped from 0 to MAX; decrement the next digit up
module bcd_dec_digit
  import pulse_dec_timer_pkg::*;
#(
  parameter logic [BCD_W-1:0] MAX = DIGIT_MAX_DEF
) (
  input  logic [BCD_W-1:0] i_digit,
  input  logic             i_dec_en,
  output logic [BCD_W-1:0] o_digit,
  output logic             o_borrow
);

  always_comb begin
    o_digit  = i_digit;
    o_borrow = 1'b0;
    if (i_dec_en) begin
      if (i_digit == '0) begin
        o_digit  = MAX;
        o_borrow = 1'b1;
      end else begin
        o_digit  = i_digit - 4'd1;
      end
    end
  end

endmodule

// File: rtl/pulse_dec_timer.sv
// BCD MM:SS countdown timer: one decrement per qualified pulse, alarm on expiry.
// Latency: data/done/alarm update one cycle after the controlling input.
// Backpressure: none; every pulse in RUN is consumed, pulses elsewhere are dropped.
//
// Ports:
//   i_clock, i_reset (async, active-low)
//   i_pulse            tick enable, one decrement per high cycle in RUN
//   i_load, i_load_min, i_load_sec  load BCD set value (clamped per digit)
//   i_start, i_stop, i_ack          run / pause / acknowledge alarm
//   o_data  {min_tens, min_ones, sec_tens, sec_ones}
//   o_running (RUN, combinational), o_done (expiry strobe), o_alarm (DONE level)
module pulse_dec_timer
  import pulse_dec_timer_pkg::*;
#(
  parameter int unsigned      ALARM_PULSES = 8,
  parameter logic [BCD_W-1:0] SEC_TENS_MAX = SEC_TENS_MAX_DEF,
  parameter logic [BCD_W-1:0] DIGIT_MAX    = DIGIT_MAX_DEF
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_pulse,
  input  logic        i_load,
  input  logic [7:0]  i_load_min,
  input  logic [7:0]  i_load_sec,
  input  logic        i_start,
  input  logic        i_stop,
  input  logic        i_ack,
  output logic [15:0] o_data,
  output logic        o_running,
  output logic        o_done,
  output logic        o_alarm
);

  localparam logic [7:0] L_ALARM_PULSES = ALARM_PULSES[7:0];

  state_t      r_state, w_state_nxt;
  logic [15:0] r_data,  w_data_nxt;
  logic        r_done,  w_done_nxt;
  logic        r_alarm, w_alarm_nxt;
  logic [7:0]  r_cnt,   w_cnt_nxt;

  logic [15:0] w_dec_data;
  logic [15:0] w_load_val;
  logic [3:0]  w_borrow;
  logic        w_unused_borrow;
  logic [7:0]  w_cnt_inc;

  // Borrow chain: seconds-ones always decrements when the result is used;
  // each higher digit only moves when the one below wraps.
  bcd_dec_digit #(.MAX(DIGIT_MAX)) u_sec_ones (
    .i_digit (r_data[3:0]),   .i_dec_en (1'b1),
    .o_digit (w_dec_data[3:0]),   .o_borrow (w_borrow[0])
  );
  bcd_dec_digit #(.MAX(SEC_TENS_MAX)) u_sec_tens (
    .i_digit (r_data[7:4]),   .i_dec_en (w_borrow[0]),
    .o_digit (w_dec_data[7:4]),   .o_borrow (w_borrow[1])
  );
  bcd_dec_digit #(.MAX(DIGIT_MAX)) u_min_ones (
    .i_digit (r_data[11:8]),  .i_dec_en (w_borrow[1]),
    .o_digit (w_dec_data[11:8]),  .o_borrow (w_borrow[2])
  );
  bcd_dec_digit #(.MAX(DIGIT_MAX)) u_min_tens (
    .i_digit (r_data[15:12]), .i_dec_en (w_borrow[2]),
    .o_digit (w_dec_data[15:12]), .o_borrow (w_borrow[3])
  );

  // The top digit can never borrow: 00:00 leaves RUN before it is decremented.
  assign w_unused_borrow = w_borrow[3];

  assign w_load_val = {clamp_digit(i_load_min[7:4], DIGIT_MAX),
                       clamp_digit(i_load_min[3:0], DIGIT_MAX),
                       clamp_digit(i_load_sec[7:4], SEC_TENS_MAX),
                       clamp_digit(i_load_sec[3:0], DIGIT_MAX)};

  assign w_cnt_inc = r_cnt + 8'd1;

  always_comb begin
    w_state_nxt = r_state;
    w_data_nxt  = r_data;
    w_done_nxt  = 1'b0;
    w_alarm_nxt = r_alarm;
    w_cnt_nxt   = r_cnt;

    if (i_load) begin
      w_state_nxt = ST_IDLE;
      w_data_nxt  = w_load_val;
      w_alarm_nxt = 1'b0;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_PAUSE: begin
          // stop outranks start even where stop itself has no effect
          if (!i_stop && i_start && (r_data != '0)) begin
            w_state_nxt = ST_RUN;
          end
        end
        ST_RUN: begin
          if (i_stop) begin
            w_state_nxt = ST_PAUSE;
          end else if (i_pulse) begin
            w_data_nxt = w_dec_data;
            if (w_dec_data == '0) begin
              w_state_nxt = ST_DONE;
              w_done_nxt  = 1'b1;
              w_alarm_nxt = 1'b1;
              w_cnt_nxt   = '0;
            end
          end
        end
        ST_DONE: begin
          if (i_ack) begin
            w_state_nxt = ST_IDLE;
            w_alarm_nxt = 1'b0;
            w_cnt_nxt   = '0;
          end else if (i_pulse) begin
            if (w_cnt_inc == L_ALARM_PULSES) begin
              w_state_nxt = ST_IDLE;
              w_alarm_nxt = 1'b0;
              w_cnt_nxt   = '0;
            end else begin
              w_cnt_nxt   = w_cnt_inc;
            end
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= ST_IDLE;
      r_data  <= '0;
      r_done  <= 1'b0;
      r_alarm <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_data  <= w_data_nxt;
      r_done  <= w_done_nxt;
      r_alarm <= w_alarm_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign o_data    = r_data;
  assign o_running = (r_state == ST_RUN);
  assign o_done    = r_done;
  assign o_alarm   = r_alarm;

endmodule

// File: tb/tb_pulse_dec_timer.sv
// Self-checking bench for pulse_dec_timer.
// Reference model tracks the remaining time as a plain count of seconds.
// Directed scenarios followed by a randomized soak.
module tb_pulse_dec_timer;

  localparam int ALARM_PULSES = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pulse, load, start, stop, ack;
  logic [7:0]  lmin, lsec;
  logic [15:0] data;
  logic        running, done, alarm;
  logic [18:0] obs;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: mode 0=idle 1=run 2=pause 3=done
  int m_secs, m_mode, m_ticks;
  bit m_done, m_alarm;

  pulse_dec_timer #(.ALARM_PULSES(ALARM_PULSES)) dut (
    .i_clock    (clk),
    .i_reset    (rst_n),
    .i_pulse    (pulse),
    .i_load     (load),
    .i_load_min (lmin),
    .i_load_sec (lsec),
    .i_start    (start),
    .i_stop     (stop),
    .i_ack      (ack),
    .o_data     (data),
    .o_running  (running),
    .o_done     (done),
    .o_alarm    (alarm)
  );

  always #5 clk = ~clk;

  assign obs = {data, running, done, alarm};

  function automatic int clampi(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic logic [18:0] exp_vec();
    int mins, s;
    logic [15:0] d;
    mins = m_secs / 60;
    s    = m_secs % 60;
    d = {4'(mins / 10), 4'(mins % 10), 4'(s / 10), 4'(s % 10)};
    return {d, (m_mode == 1), m_done, m_alarm};
  endfunction

  task automatic model_reset();
    m_secs = 0; m_mode = 0; m_ticks = 0; m_done = 0; m_alarm = 0;
  endtask

  task automatic model_step();
    m_done = 0;
    if (!rst_n) begin
      model_reset();
    end else if (load) begin
      m_secs  = (clampi(int'(lmin[7:4]), 9) * 10 + clampi(int'(lmin[3:0]), 9)) * 60
              +  clampi(int'(lsec[7:4]), 5) * 10 + clampi(int'(lsec[3:0]), 9);
      m_mode  = 0;
      m_alarm = 0;
      m_ticks = 0;
    end else begin
      case (m_mode)
        0, 2: if (!stop && start && m_secs != 0) m_mode = 1;
        1: begin
          if (stop) m_mode = 2;
          else if (pulse) begin
            m_secs = m_secs - 1;
            if (m_secs == 0) begin
              m_mode = 3; m_done = 1; m_alarm = 1; m_ticks = 0;
            end
          end
        end
        default: begin
          if (ack) begin
            m_mode = 0; m_alarm = 0; m_ticks = 0;
          end else if (pulse) begin
            m_ticks = m_ticks + 1;
            if (m_ticks == ALARM_PULSES) begin
              m_mode = 0; m_alarm = 0; m_ticks = 0;
            end
          end
        end
      endcase
    end
  endtask

  // Advance one clock; model sees the same inputs as the DUT. Returns #1 after the edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    pulse = 0; load = 0; start = 0; stop = 0; ack = 0; lmin = 8'h00; lsec = 8'h00;
  endtask

  task automatic do_load(input logic [7:0] mn, input logic [7:0] sc);
    idle_inputs();
    load = 1; lmin = mn; lsec = sc;
    tick();
    load = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    model_reset();
    #12;
    n_checks++;
    if (obs !== exp_vec()) begin
      n_fail++;
      $display("FAIL reset: got %h req %h", obs, exp_vec());
    end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_countdown();
    int dones = 0;
    do_load(8'h00, 8'h05);
    start = 1;
    tick();
    start = 0; pulse = 1;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (done) dones++;
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL countdown step%0d: got %h req %h", i, obs, exp_vec());
      end
      if (i == 4) begin
        n_checks++;
        if ({data, done, alarm} !== {16'h0000, 1'b1, 1'b1}) begin
          n_fail++;
          $display("FAIL countdown_expiry: got %h/%b%b req 0000/11", data, done, alarm);
        end
      end
    end
    pulse = 0;
    n_checks++;
    if (dones !== 1) begin
      n_fail++;
      $display("FAIL countdown_done_count: got %0d req 1", dones);
    end
  endtask

  task automatic test_borrow();
    do_load(8'h10, 8'h00);
    start = 1; tick(); start = 0;
    pulse = 1; tick(); pulse = 0;
    n_checks++;
    if (data !== 16'h0959 || obs !== exp_vec()) begin
      n_fail++;
      $display("FAIL borrow_1000: got %h req 0959 (%h)", data, exp_vec());
    end
    do_load(8'h01, 8'h00);
    start = 1; tick(); start = 0;
    pulse = 1; tick(); pulse = 0;
    n_checks++;
    if (data !== 16'h0059 || obs !== exp_vec()) begin
      n_fail++;
      $display("FAIL borrow_0100: got %h req 0059 (%h)", data, exp_vec());
    end
  endtask

  task automatic test_clamp();
    do_load(8'hAF, 8'h7C);
    n_checks++;
    if (data !== 16'h9959 || obs !== exp_vec()) begin
      n_fail++;
      $display("FAIL clamp: got %h req 9959", data);
    end
    do_load(8'h00, 8'h00);
    start = 1; tick(); start = 0;
    tick();
    n_checks++;
    if (running !== 1'b0 || obs !== exp_vec()) begin
      n_fail++;
      $display("FAIL start_at_zero: got running=%b req 0", running);
    end
  endtask

  task automatic test_pause_resume();
    do_load(8'h00, 8'h10);
    start = 1; tick(); start = 0;
    pulse = 1;
    for (int i = 0; i < 3; i++) tick();
    pulse = 0;
    stop = 1; tick(); stop = 0;
    pulse = 1;
    for (int i = 0; i < 5; i++) tick();
    pulse = 0;
    n_checks++;
    if (data !== 16'h0007 || running !== 1'b0 || obs !== exp_vec()) begin
      n_fail++;
      $display("FAIL paused_hold: got %h run=%b req 0007 run=0", data, running);
    end
    start = 1; tick(); start = 0;
    pulse = 1;
    for (int i = 0; i < 7; i++) tick();
    pulse = 0;
    n_checks++;
    if ({data, done, alarm} !== {16'h0000, 1'b1, 1'b1} || obs !== exp_vec()) begin
      n_fail++;
      $display("FAIL resume_expiry: got %h/%b%b req 0000/11", data, done, alarm);
    end
  endtask

  task automatic expire_one();
    do_load(8'h00, 8'h01);
    start = 1; tick(); start = 0;
    pulse = 1; tick(); pulse = 0;
  endtask

  task automatic test_alarm();
    expire_one();
    pulse = 1;
    for (int i = 0; i < ALARM_PULSES; i++) begin
      tick();
      n_checks++;
      if (obs !== exp_vec() || alarm !== (i < ALARM_PULSES - 1)) begin
        n_fail++;
        $display("FAIL alarm_timeout tick%0d: got %h req %h", i, obs, exp_vec());
      end
    end
    pulse = 0;
    expire_one();
    pulse = 1; tick(); tick(); pulse = 0;
    ack = 1; tick(); ack = 0;
    n_checks++;
    if (alarm !== 1'b0 || obs !== exp_vec()) begin
      n_fail++;
      $display("FAIL alarm_ack: got alarm=%b req 0", alarm);
    end
  endtask

  task automatic test_priority_reset();
    int dones = 0;
    idle_inputs();
    load = 1; start = 1; lmin = 8'h02; lsec = 8'h34;
    tick();
    load = 0; start = 0;
    n_checks++;
    if (data !== 16'h0234 || running !== 1'b0 || obs !== exp_vec()) begin
      n_fail++;
      $display("FAIL load_beats_start: got %h run=%b req 0234 run=0", data, running);
    end
    do_load(8'h00, 8'h05);
    start = 1; tick(); start = 0;
    pulse = 1; tick(); tick();
    #2 rst_n = 0;
    model_reset();
    #1;
    n_checks++;
    if (data !== 16'h0000 || running !== 1'b0 || obs !== exp_vec()) begin
      n_fail++;
      $display("FAIL reset_mid_run: got %h run=%b req 0000 run=0", data, running);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done) dones++;
      if (i == 1) rst_n = 1;
    end
    pulse = 0;
    n_checks++;
    if (dones !== 0 || obs !== exp_vec()) begin
      n_fail++;
      $display("FAIL reset_no_done: got %0d strobes req 0", dones);
    end
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 1500; i++) begin
      idle_inputs();
      rst_n = ($urandom_range(0, 299) != 0);
      load  = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 1) == 0) begin
        lmin = 8'h00;
        lsec = 8'($urandom_range(0, 20));
      end else begin
        lmin = 8'($urandom);
        lsec = 8'($urandom);
      end
      start = ($urandom_range(0, 3) == 0);
      stop  = ($urandom_range(0, 11) == 0);
      ack   = ($urandom_range(0, 15) == 0);
      pulse = ($urandom_range(0, 1) == 0);
      tick();
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++;
        bad++;
        if (bad <= 10) $display("FAIL random cyc%0d: got %h req %h", i, obs, exp_vec());
      end
    end
    rst_n = 1;
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_borrow();
    test_clamp();
    test_pause_resume();
    test_alarm();
    test_priority_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
